// File: rtl/ita_scroll_display_if.sv
`default_nettype none
// ==== ita_scroll_display_if : host bus and display outputs of the scroll display | rev 1.0 ====
interface ita_scroll_display_if #(
   parameter int N_DIGITS  = 12,
   parameter int MSG_DEPTH = 16
);
   localparam int AW = $clog2(MSG_DEPTH);

   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [5:0]          char_data;
   logic                len_we;
   logic [AW:0]         len_data;
   logic                scroll_en;
   logic [7:0]          scroll_frames;
   logic                blank;
   logic [N_DIGITS-1:0] sel;
   logic [13:0]         segm;
   logic                frame_tick;

   modport master (
      output wr_en, wr_addr, char_data, len_we, len_data, scroll_en, scroll_frames, blank,
      input  sel, segm, frame_tick
   );

   modport slave (
      input  wr_en, wr_addr, char_data, len_we, len_data, scroll_en, scroll_frames, blank,
      output sel, segm, frame_tick
   );
endinterface
`default_nettype wire

// File: rtl/ita_scroll_display.sv
`default_nettype none
// ==== ita_scroll_display : 14-segment digit scanner with message RAM, font ROM and marquee | rev 1.0 ====
module ita_scroll_display #(
   parameter int N_DIGITS  = 12,
   parameter int MSG_DEPTH = 16,
   parameter int GAP       = 4,
   parameter int SCAN_DIV  = 1
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   ita_scroll_display_if.slave bus
);
   localparam int AW = $clog2(MSG_DEPTH);
   localparam int IW = $clog2(N_DIGITS);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   // Wide enough for offset + idx before the wrap subtract.
   localparam int LW = $clog2(MSG_DEPTH + GAP + N_DIGITS + 1);

   localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
   localparam logic [AW:0]   LEN_MAX  = (AW+1)'(MSG_DEPTH);
   localparam logic [AW:0]   LEN_RST  = (AW+1)'(7);

   function automatic logic [5:0] init_char(input int i);
      case (i)
         0:       init_char = 6'd7;
         1:       init_char = 6'd15;
         2:       init_char = 6'd14;
         3:       init_char = 6'd26;
         4:       init_char = 6'd1;
         5:       init_char = 6'd12;
         6:       init_char = 6'd5;
         default: init_char = 6'd0;
      endcase
   endfunction

   // Bit order {a,b,c,d,e,f,g1,g2,h,i,j,k,l,m}, a in bit 13.
   function automatic logic [13:0] font(input logic [5:0] c);
      case (c)
         6'd1:    font = 14'b11101111000000;
         6'd2:    font = 14'b11110001010010;
         6'd3:    font = 14'b10011100000000;
         6'd4:    font = 14'b11110000010010;
         6'd5:    font = 14'b10011110000000;
         6'd6:    font = 14'b10001110000000;
         6'd7:    font = 14'b10111101000000;
         6'd8:    font = 14'b01101111000000;
         6'd9:    font = 14'b10010000010010;
         6'd10:   font = 14'b01111000000000;
         6'd11:   font = 14'b00001110001100;
         6'd12:   font = 14'b00011100000000;
         6'd13:   font = 14'b01101100101000;
         6'd14:   font = 14'b01101100100100;
         6'd15:   font = 14'b11111100000000;
         6'd16:   font = 14'b11001111000000;
         6'd17:   font = 14'b11111100000100;
         6'd18:   font = 14'b11001111000100;
         6'd19:   font = 14'b10110111000000;
         6'd20:   font = 14'b10000000010010;
         6'd21:   font = 14'b01111100000000;
         6'd22:   font = 14'b00001100001001;
         6'd23:   font = 14'b01101100000101;
         6'd24:   font = 14'b00000000101101;
         6'd25:   font = 14'b00000000101010;
         6'd26:   font = 14'b10010000001001;
         6'd27:   font = 14'b11111100001001;
         6'd28:   font = 14'b01100000000000;
         6'd29:   font = 14'b11011011000000;
         6'd30:   font = 14'b11110011000000;
         6'd31:   font = 14'b01100111000000;
         6'd32:   font = 14'b10110111000000;
         6'd33:   font = 14'b10111111000000;
         6'd34:   font = 14'b11100000000000;
         6'd35:   font = 14'b11111111000000;
         6'd36:   font = 14'b11110111000000;
         default: font = 14'b0;
      endcase
   endfunction

   logic [5:0]          ram_q [MSG_DEPTH];
   logic [AW:0]         msg_len_q, msg_len_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [PW-1:0]       pre_q, pre_d;
   logic [LW-1:0]       offset_q, offset_d;
   logic [7:0]          frame_cnt_q, frame_cnt_d;
   logic [N_DIGITS-1:0] sel_q, sel_d;
   logic [13:0]         segm_q, segm_d;
   logic                frame_tick_q, frame_tick_d;

   logic          step, last_digit, frame_last, is_space;
   logic [LW-1:0] len_l, offset_eff, offset_inc, pos_sum, pos;
   logic [AW-1:0] rd_addr;
   logic [7:0]    frames_m1;

   always_comb begin
      step       = (pre_q == PRE_LAST);
      last_digit = (idx_q == IDX_LAST);
      len_l      = LW'(msg_len_q) + (bus.scroll_en ? LW'(GAP) : LW'(0));
      // An offset left over from a longer cycle length restarts at 0.
      offset_eff = (offset_q >= len_l) ? '0 : offset_q;
      pos_sum    = offset_eff + LW'(idx_q);
      pos        = (pos_sum >= len_l) ? (pos_sum - len_l) : pos_sum;
      rd_addr    = pos[AW-1:0];
      is_space   = (pos >= LW'(msg_len_q)) ||
                   (!bus.scroll_en && (LW'(idx_q) >= LW'(msg_len_q)));
      offset_inc = ((offset_eff + LW'(1)) >= len_l) ? '0 : (offset_eff + LW'(1));
      frames_m1  = (bus.scroll_frames == 8'd0) ? 8'd0 : (bus.scroll_frames - 8'd1);
      frame_last = (frame_cnt_q == frames_m1);
   end

   always_comb begin
      pre_d        = step ? '0 : (pre_q + PW'(1));
      idx_d        = idx_q;
      offset_d     = offset_q;
      frame_cnt_d  = frame_cnt_q;
      msg_len_d    = msg_len_q;
      sel_d        = sel_q;
      segm_d       = segm_q;
      frame_tick_d = 1'b0;
      if (step) begin
         idx_d        = last_digit ? '0 : (idx_q + IW'(1));
         sel_d        = bus.blank ? '0 : (N_DIGITS'(1) << idx_q);
         segm_d       = (bus.blank || is_space) ? '0 : font(ram_q[rd_addr]);
         frame_tick_d = last_digit;
         offset_d     = offset_eff;
         if (last_digit && bus.scroll_en) begin
            if (frame_last) begin
               offset_d    = offset_inc;
               frame_cnt_d = '0;
            end else begin
               frame_cnt_d = frame_cnt_q + 8'd1;
            end
         end
      end
      if (bus.len_we) begin
         msg_len_d   = (bus.len_data > LEN_MAX) ? LEN_MAX : bus.len_data;
         offset_d    = '0;
         frame_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msg_len_q    <= LEN_RST;
         idx_q        <= '0;
         pre_q        <= '0;
         offset_q     <= '0;
         frame_cnt_q  <= '0;
         sel_q        <= '0;
         segm_q       <= '0;
         frame_tick_q <= 1'b0;
      end else begin
         msg_len_q    <= msg_len_d;
         idx_q        <= idx_d;
         pre_q        <= pre_d;
         offset_q     <= offset_d;
         frame_cnt_q  <= frame_cnt_d;
         sel_q        <= sel_d;
         segm_q       <= segm_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   // Writes land at the edge, so a step in the write cycle still reads the old char.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MSG_DEPTH; i++) begin
            ram_q[i] <= init_char(i);
         end
      end else if (bus.wr_en) begin
         ram_q[bus.wr_addr] <= bus.char_data;
      end
   end

   assign bus.sel        = sel_q;
   assign bus.segm       = segm_q;
   assign bus.frame_tick = frame_tick_q;
endmodule
`default_nettype wire

// File: tb/tb_ita_scroll_display.sv
`default_nettype none
// ==== tb_ita_scroll_display : directed bench for ita_scroll_display | rev 1.0 ====
module tb_ita_scroll_display;
   localparam logic [13:0] F_G = 14'b10111101000000;
   localparam logic [13:0] F_O = 14'b11111100000000;
   localparam logic [13:0] F_N = 14'b01101100100100;
   localparam logic [13:0] F_Z = 14'b10010000001001;
   localparam logic [13:0] F_A = 14'b11101111000000;
   localparam logic [13:0] F_L = 14'b00011100000000;
   localparam logic [13:0] F_E = 14'b10011110000000;
   localparam logic [13:0] F_H = 14'b01101111000000;
   localparam logic [13:0] F_I = 14'b10010000010010;
   localparam logic [13:0] F_1 = 14'b01100000000000;
   localparam logic [13:0] F_2 = 14'b11011011000000;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   ita_scroll_display_if #(.N_DIGITS(12), .MSG_DEPTH(16)) ifc ();
   ita_scroll_display_if #(.N_DIGITS(12), .MSG_DEPTH(16)) ifc4 ();

   ita_scroll_display #(.N_DIGITS(12), .MSG_DEPTH(16), .GAP(4), .SCAN_DIV(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(ifc));
   ita_scroll_display #(.N_DIGITS(12), .MSG_DEPTH(16), .GAP(4), .SCAN_DIV(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .bus(ifc4));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_frame();
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (ifc.frame_tick === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL wait_frame: frame_tick stayed 0 for 40 cycles, required 1"); end
   endtask

   task automatic idle_inputs();
      ifc.wr_en = 0; ifc.wr_addr = '0; ifc.char_data = '0; ifc.len_we = 0; ifc.len_data = '0;
      ifc.scroll_en = 0; ifc.scroll_frames = '0; ifc.blank = 0;
      ifc4.wr_en = 0; ifc4.wr_addr = '0; ifc4.char_data = '0; ifc4.len_we = 0; ifc4.len_data = '0;
      ifc4.scroll_en = 0; ifc4.scroll_frames = '0; ifc4.blank = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #1;
      checks++; if (ifc.sel !== 12'h000) begin errors++; $display("FAIL reset_sel: got %h required %h", ifc.sel, 12'h000); end
      checks++; if (ifc.segm !== 14'h0) begin errors++; $display("FAIL reset_segm: got %h required %h", ifc.segm, 14'h0); end
      checks++; if (ifc.frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b required 0", ifc.frame_tick); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_default_scan();
      logic [13:0] exp_seg [12];
      logic [11:0] exp_sel;
      exp_seg = '{F_G, F_O, F_N, F_Z, F_A, F_L, F_E, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0};
      for (int k = 0; k < 12; k++) begin
         tick();
         exp_sel = 12'd1 << k;
         checks++; if (ifc.sel !== exp_sel) begin errors++; $display("FAIL scan_sel[%0d]: got %h required %h", k, ifc.sel, exp_sel); end
         checks++; if (ifc.segm !== exp_seg[k]) begin errors++; $display("FAIL scan_segm[%0d]: got %b required %b", k, ifc.segm, exp_seg[k]); end
         checks++; if (ifc.frame_tick !== (k == 11)) begin errors++; $display("FAIL scan_tick[%0d]: got %b required %b", k, ifc.frame_tick, (k == 11)); end
      end
      tick();
      checks++; if (ifc.sel !== 12'h001) begin errors++; $display("FAIL scan_repeat_sel: got %h required 001", ifc.sel); end
      checks++; if (ifc.segm !== F_G) begin errors++; $display("FAIL scan_repeat_segm: got %b required %b", ifc.segm, F_G); end
      checks++; if (ifc.frame_tick !== 1'b0) begin errors++; $display("FAIL scan_repeat_tick: got %b required 0", ifc.frame_tick); end
   endtask

   task automatic test_scroll();
      wait_frame();
      ifc.len_we = 1; ifc.len_data = 5'd7; ifc.scroll_en = 1; ifc.scroll_frames = 8'd2;
      tick();
      ifc.len_we = 0;
      checks++; if (ifc.segm !== F_G) begin errors++; $display("FAIL scroll_start: got %b required %b", ifc.segm, F_G); end
      repeat (2) wait_frame();
      tick();
      checks++; if (ifc.segm !== F_O) begin errors++; $display("FAIL scroll_adv1_d0: got %b required %b", ifc.segm, F_O); end
      repeat (12) wait_frame();
      tick();
      checks++; if (ifc.sel !== 12'h001) begin errors++; $display("FAIL scroll_adv7_sel0: got %h required 001", ifc.sel); end
      checks++; if (ifc.segm !== 14'h0) begin errors++; $display("FAIL scroll_adv7_d0: got %b required 0", ifc.segm); end
      repeat (4) tick();
      checks++; if (ifc.sel !== 12'h010) begin errors++; $display("FAIL scroll_adv7_sel4: got %h required 010", ifc.sel); end
      checks++; if (ifc.segm !== F_G) begin errors++; $display("FAIL scroll_adv7_d4: got %b required %b", ifc.segm, F_G); end
      repeat (8) wait_frame();
      tick();
      checks++; if (ifc.segm !== F_G) begin errors++; $display("FAIL scroll_wrap_d0: got %b required %b", ifc.segm, F_G); end
      tick();
      checks++; if (ifc.segm !== F_O) begin errors++; $display("FAIL scroll_wrap_d1: got %b required %b", ifc.segm, F_O); end
   endtask

   task automatic test_write_message();
      logic [5:0]  codes [4];
      logic [13:0] exp_seg [12];
      logic [11:0] exp_sel;
      codes   = '{6'd8, 6'd9, 6'd28, 6'd29};
      exp_seg = '{F_H, F_I, F_1, F_2, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0};
      ifc.scroll_en = 0;
      for (int a = 0; a < 4; a++) begin
         ifc.wr_en = 1; ifc.wr_addr = 4'(a); ifc.char_data = codes[a];
         tick();
      end
      ifc.wr_en = 0;
      ifc.len_we = 1; ifc.len_data = 5'd4;
      tick();
      ifc.len_we = 0;
      wait_frame();
      for (int k = 0; k < 12; k++) begin
         tick();
         exp_sel = 12'd1 << k;
         checks++; if (ifc.sel !== exp_sel) begin errors++; $display("FAIL hi12_sel[%0d]: got %h required %h", k, ifc.sel, exp_sel); end
         checks++; if (ifc.segm !== exp_seg[k]) begin errors++; $display("FAIL hi12_segm[%0d]: got %b required %b", k, ifc.segm, exp_seg[k]); end
      end
   endtask

   task automatic test_blank();
      repeat (3) tick();
      ifc.blank = 1;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++; if (ifc.sel !== 12'h000) begin errors++; $display("FAIL blank_sel[%0d]: got %h required 000", k, ifc.sel); end
         checks++; if (ifc.segm !== 14'h0) begin errors++; $display("FAIL blank_segm[%0d]: got %b required 0", k, ifc.segm); end
      end
      ifc.blank = 0;
      tick();
      checks++; if (ifc.sel !== 12'h100) begin errors++; $display("FAIL blank_resume: got %h required 100", ifc.sel); end
   endtask

   task automatic test_back_to_back_write();
      wait_frame();
      ifc.wr_en = 1; ifc.wr_addr = 4'd0; ifc.char_data = 6'd1;
      tick();
      ifc.wr_en = 0;
      checks++; if (ifc.segm !== F_H) begin errors++; $display("FAIL write_same_cycle: got %b required %b", ifc.segm, F_H); end
      wait_frame();
      tick();
      checks++; if (ifc.segm !== F_A) begin errors++; $display("FAIL write_visible: got %b required %b", ifc.segm, F_A); end
   endtask

   task automatic test_length();
      logic [11:0] exp_sel;
      ifc.len_we = 1; ifc.len_data = 5'd0;
      tick();
      ifc.len_we = 0;
      wait_frame();
      for (int k = 0; k < 12; k++) begin
         tick();
         exp_sel = 12'd1 << k;
         checks++; if (ifc.sel !== exp_sel) begin errors++; $display("FAIL len0_sel[%0d]: got %h required %h", k, ifc.sel, exp_sel); end
         checks++; if (ifc.segm !== 14'h0) begin errors++; $display("FAIL len0_segm[%0d]: got %b required 0", k, ifc.segm); end
      end
      // len 31 clamps to 16, so the scroll cycle is 20 positions.
      ifc.len_we = 1; ifc.len_data = 5'd31; ifc.scroll_en = 1; ifc.scroll_frames = 8'd0;
      tick();
      ifc.len_we = 0;
      repeat (8) wait_frame();
      repeat (9) tick();
      checks++; if (ifc.sel !== 12'h100) begin errors++; $display("FAIL clamp_off8_sel8: got %h required 100", ifc.sel); end
      checks++; if (ifc.segm !== 14'h0) begin errors++; $display("FAIL clamp_off8_d8: got %b required 0", ifc.segm); end
      repeat (3) tick();
      checks++; if (ifc.segm !== 14'h0) begin errors++; $display("FAIL clamp_off8_d11: got %b required 0", ifc.segm); end
      repeat (3) wait_frame();
      repeat (9) tick();
      checks++; if (ifc.segm !== F_A) begin errors++; $display("FAIL clamp_off12_d8: got %b required %b", ifc.segm, F_A); end
      repeat (3) tick();
      checks++; if (ifc.segm !== F_2) begin errors++; $display("FAIL clamp_off12_d11: got %b required %b", ifc.segm, F_2); end
   endtask

   task automatic test_reset_midscan();
      idle_inputs();
      repeat (8) tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (ifc4.sel !== 12'h000) begin errors++; $display("FAIL midrst_sel4: got %h required 000", ifc4.sel); end
      checks++; if (ifc4.segm !== 14'h0) begin errors++; $display("FAIL midrst_segm4: got %b required 0", ifc4.segm); end
      checks++; if (ifc.sel !== 12'h000) begin errors++; $display("FAIL midrst_sel: got %h required 000", ifc.sel); end
      checks++; if (ifc.segm !== 14'h0) begin errors++; $display("FAIL midrst_segm: got %b required 0", ifc.segm); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if (ifc.segm !== F_G) begin errors++; $display("FAIL reload_d0: got %b required %b", ifc.segm, F_G); end
      checks++; if (ifc4.sel !== 12'h000) begin errors++; $display("FAIL div4_e1: got %h required 000", ifc4.sel); end
      tick();
      checks++; if (ifc.segm !== F_O) begin errors++; $display("FAIL reload_d1: got %b required %b", ifc.segm, F_O); end
      checks++; if (ifc4.sel !== 12'h000) begin errors++; $display("FAIL div4_e2: got %h required 000", ifc4.sel); end
      tick();
      checks++; if (ifc4.sel !== 12'h000) begin errors++; $display("FAIL div4_e3: got %h required 000", ifc4.sel); end
      tick();
      checks++; if (ifc4.sel !== 12'h001) begin errors++; $display("FAIL div4_e4_sel: got %h required 001", ifc4.sel); end
      checks++; if (ifc4.segm !== F_G) begin errors++; $display("FAIL div4_e4_segm: got %b required %b", ifc4.segm, F_G); end
      repeat (3) tick();
      checks++; if (ifc4.sel !== 12'h001) begin errors++; $display("FAIL div4_e7_hold: got %h required 001", ifc4.sel); end
      tick();
      checks++; if (ifc4.sel !== 12'h002) begin errors++; $display("FAIL div4_e8_sel: got %h required 002", ifc4.sel); end
      checks++; if (ifc4.segm !== F_O) begin errors++; $display("FAIL div4_e8_segm: got %b required %b", ifc4.segm, F_O); end
   endtask

   initial begin
      test_reset();
      test_default_scan();
      test_scroll();
      test_write_message();
      test_blank();
      test_back_to_back_write();
      test_length();
      test_reset_midscan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
